// File: rtl/lct_l1a_window_pkg.sv
// rtl/lct_l1a_window_pkg.sv - shared types and constants for the LCT/L1A coincidence window
package lct_l1a_window_pkg;

    // Statistics counter width when the instantiator does not override it.
    localparam int CNT_W_DEF = 16;

    // Window length field width, matched to the delay-line address width.
    localparam int WIN_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    // The arrival cycle is the first cycle of a WIN+1 window, so the counter
    // loaded on arrival holds the number of OPEN cycles that follow minus one.
    // A reload value is only meaningful for win != 0; win == 0 never opens.
    function automatic logic [WIN_W-1:0] win_reload(input logic [WIN_W-1:0] win);
        return win - WIN_W'(1);
    endfunction

endpackage

// File: rtl/lct_l1a_window_if.sv
// rtl/lct_l1a_window_if.sv - control, trigger and statistics bundle of the LCT/L1A window
interface lct_l1a_window_if #(
    parameter int CNT_W = lct_l1a_window_pkg::CNT_W_DEF
);
    logic                                 CE;
    logic                                 LCT_DLY;
    logic                                 L1A;
    logic [lct_l1a_window_pkg::WIN_W-1:0] WIN;
    logic                                 CLR_CNT;

    logic                                 L1A_MATCH;
    logic                                 L1A_NOMATCH;
    logic                                 LCT_TMO;
    logic                                 WIN_OPEN;
    logic [CNT_W-1:0]                     MATCH_CNT;
    logic [CNT_W-1:0]                     NOMATCH_CNT;
    logic [CNT_W-1:0]                     TMO_CNT;
    logic [CNT_W-1:0]                     OVLP_CNT;

    modport master (
        output CE, LCT_DLY, L1A, WIN, CLR_CNT,
        input  L1A_MATCH, L1A_NOMATCH, LCT_TMO, WIN_OPEN,
        input  MATCH_CNT, NOMATCH_CNT, TMO_CNT, OVLP_CNT
    );

    modport slave (
        input  CE, LCT_DLY, L1A, WIN, CLR_CNT,
        output L1A_MATCH, L1A_NOMATCH, LCT_TMO, WIN_OPEN,
        output MATCH_CNT, NOMATCH_CNT, TMO_CNT, OVLP_CNT
    );

endinterface

// File: rtl/lct_l1a_window_sat_cnt.sv
// rtl/lct_l1a_window_sat_cnt.sv - saturating event counter with synchronous clear
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CLR,
    input  logic         INC,
    output logic [W-1:0] Q
);

    // Count events, stick at all-ones, and let clear win over a same-cycle event.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q <= '0;
        end else if (CLR) begin
            Q <= '0;
        end else if (INC && (Q != {W{1'b1}})) begin
            Q <= Q + W'(1);
        end
    end

endmodule

// File: rtl/lct_l1a_window.sv
// rtl/lct_l1a_window.sv - coincidence window between delayed LCT and L1A with statistics
module lct_l1a_window
    import lct_l1a_window_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    lct_l1a_window_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIN_W-1:0] wcnt;
    logic [WIN_W-1:0] wcnt_nxt;
    logic             open_win;

    logic             ev_match;
    logic             ev_nomatch;
    logic             ev_tmo;
    logic             ev_ovlp;

    logic             match_q;
    logic             nomatch_q;
    logic             tmo_q;

    // Decode this cycle's events and the next window state; nothing moves while CE is low.
    always_comb begin
        ev_match   = 1'b0;
        ev_nomatch = 1'b0;
        ev_tmo     = 1'b0;
        ev_ovlp    = 1'b0;
        open_win   = 1'b0;
        state_nxt  = state;
        wcnt_nxt   = wcnt;

        if (bus.CE) begin
            case (state)
                ST_IDLE: begin
                    if (bus.L1A) begin
                        // An L1A on the arrival cycle consumes the new window immediately.
                        ev_match   = bus.LCT_DLY;
                        ev_nomatch = ~bus.LCT_DLY;
                    end else if (bus.LCT_DLY) begin
                        open_win = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (bus.LCT_DLY) begin
                        // The old window is dropped silently; an L1A this cycle still
                        // consumes it, and the new LCT restarts a fresh window.
                        ev_ovlp  = 1'b1;
                        ev_match = bus.L1A;
                        open_win = 1'b1;
                    end else if (bus.L1A) begin
                        ev_match  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (wcnt == '0) begin
                        ev_tmo    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        wcnt_nxt = wcnt - WIN_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase

            // A fresh window with WIN=0 is just the arrival cycle, already spent
            // without a matching L1A, so it expires on the spot.
            if (open_win) begin
                if (bus.WIN == '0) begin
                    ev_tmo    = 1'b1;
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = '0;
                end else begin
                    state_nxt = ST_OPEN;
                    wcnt_nxt  = win_reload(bus.WIN);
                end
            end
        end
    end

    // Window FSM, window counter and registered event pulses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            match_q   <= 1'b0;
            nomatch_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            match_q   <= ev_match;
            nomatch_q <= ev_nomatch;
            tmo_q     <= ev_tmo;
        end
    end

    assign bus.L1A_MATCH   = match_q;
    assign bus.L1A_NOMATCH = nomatch_q;
    assign bus.LCT_TMO     = tmo_q;
    assign bus.WIN_OPEN    = (state == ST_OPEN);

    sat_cnt #(.W(CNT_W)) u_match_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (bus.CLR_CNT),
        .INC   (ev_match),
        .Q     (bus.MATCH_CNT)
    );

    sat_cnt #(.W(CNT_W)) u_nomatch_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (bus.CLR_CNT),
        .INC   (ev_nomatch),
        .Q     (bus.NOMATCH_CNT)
    );

    sat_cnt #(.W(CNT_W)) u_tmo_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (bus.CLR_CNT),
        .INC   (ev_tmo),
        .Q     (bus.TMO_CNT)
    );

    sat_cnt #(.W(CNT_W)) u_ovlp_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (bus.CLR_CNT),
        .INC   (ev_ovlp),
        .Q     (bus.OVLP_CNT)
    );

endmodule

// File: tb/tb_lct_l1a_window.sv
// tb/tb_lct_l1a_window.sv - self-checking bench for lct_l1a_window
module tb_lct_l1a_window;

    localparam int CW  = 16;
    localparam int SAT = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    lct_l1a_window_if #(.CNT_W(CW)) bus ();

    lct_l1a_window #(.CNT_W(CW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a window is an absolute deadline in CE-cycle time.
    bit m_open;
    int m_deadline;
    int m_n;
    int m_cnt [4];
    bit e_match, e_nomatch, e_tmo;

    typedef struct {
        bit         ce;
        bit         lct;
        bit         l1a;
        logic [3:0] win;
        bit         match;
        bit         nomatch;
        bit         tmo;
        bit         open;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input bit ce, input bit lct, input bit l1a,
                          input logic [3:0] win, input bit clr);
        bus.CE      = ce;
        bus.LCT_DLY = lct;
        bus.L1A     = l1a;
        bus.WIN     = win;
        bus.CLR_CNT = clr;
    endtask

    function automatic void model_step();
        bit was;
        bit ev [4];
        e_match   = 1'b0;
        e_nomatch = 1'b0;
        e_tmo     = 1'b0;
        for (int k = 0; k < 4; k++) ev[k] = 1'b0;
        if (!RST_N) begin
            m_open     = 1'b0;
            m_deadline = 0;
            m_n        = 0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            return;
        end
        if (bus.CE) begin
            was = m_open;
            if (bus.L1A) begin
                if (was || bus.LCT_DLY) e_match = 1'b1;
                else                    e_nomatch = 1'b1;
            end
            if (bus.LCT_DLY && was) ev[3] = 1'b1;
            if (bus.LCT_DLY) begin
                if (bus.L1A && !was) begin
                    m_open = 1'b0;
                end else begin
                    m_open     = 1'b1;
                    m_deadline = m_n + int'(bus.WIN);
                end
            end else if (bus.L1A) begin
                m_open = 1'b0;
            end
            if (m_open && (m_deadline == m_n)) begin
                e_tmo  = 1'b1;
                m_open = 1'b0;
            end
            m_n++;
        end
        ev[0] = e_match;
        ev[1] = e_nomatch;
        ev[2] = e_tmo;
        for (int k = 0; k < 4; k++) begin
            if (bus.CLR_CNT)  m_cnt[k] = 0;
            else if (ev[k])   m_cnt[k] = (m_cnt[k] < SAT) ? m_cnt[k] + 1 : SAT;
        end
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, " match"},   int'(bus.L1A_MATCH),   int'(e_match));
        chk({tag, " nomatch"}, int'(bus.L1A_NOMATCH), int'(e_nomatch));
        chk({tag, " tmo"},     int'(bus.LCT_TMO),     int'(e_tmo));
        chk({tag, " open"},    int'(bus.WIN_OPEN),    int'(m_open));
        chk({tag, " match_cnt"},   int'(bus.MATCH_CNT),   m_cnt[0]);
        chk({tag, " nomatch_cnt"}, int'(bus.NOMATCH_CNT), m_cnt[1]);
        chk({tag, " tmo_cnt"},     int'(bus.TMO_CNT),     m_cnt[2]);
        chk({tag, " ovlp_cnt"},    int'(bus.OVLP_CNT),    m_cnt[3]);
    endtask

    task automatic step(input bit do_check, input string tag);
        model_step();
        @(posedge CLK);
        #1;
        if (do_check) compare_model(tag);
    endtask

    initial begin
        RST_N = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reset state.
        step(1'b1, "reset0");
        step(1'b1, "reset1");
        chk("reset match_cnt", int'(bus.MATCH_CNT), 0);
        chk("reset open", int'(bus.WIN_OPEN), 0);
        RST_N = 1'b1;

        // Directed vectors: {ce, lct, l1a, win, match, nomatch, tmo, open}.
        // WIN=3, L1A on the last window cycle matches.
        tbl.push_back('{1, 1, 0, 4'd3, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd3, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd3, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 1, 4'd3, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd3, 0, 0, 0, 0});
        // WIN=3, L1A one cycle too late: timeout, then no-match.
        tbl.push_back('{1, 1, 0, 4'd3, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd3, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd3, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd3, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 1, 4'd3, 0, 1, 0, 0});
        // LCT and L1A together in IDLE; WIN=0 LCT alone times out at once.
        tbl.push_back('{1, 1, 1, 4'd0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 4'd0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 4'd0, 0, 0, 0, 0});
        // WIN=5, second LCT two cycles later restarts the window.
        tbl.push_back('{1, 1, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd5, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd5, 0, 0, 1, 0});
        // WIN=2 with CE low for four cycles; L1A during CE=0 is ignored.
        tbl.push_back('{1, 1, 0, 4'd2, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 4'd2, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 4'd2, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 4'd2, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 4'd2, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd2, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 4'd2, 0, 0, 1, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].ce, tbl[i].lct, tbl[i].l1a, tbl[i].win, 1'b0);
            step(1'b1, $sformatf("vec%0d model", i));
            chk($sformatf("vec%0d match", i),   int'(bus.L1A_MATCH),   int'(tbl[i].match));
            chk($sformatf("vec%0d nomatch", i), int'(bus.L1A_NOMATCH), int'(tbl[i].nomatch));
            chk($sformatf("vec%0d tmo", i),     int'(bus.LCT_TMO),     int'(tbl[i].tmo));
            chk($sformatf("vec%0d open", i),    int'(bus.WIN_OPEN),    int'(tbl[i].open));
        end
        chk("table match_cnt",   int'(bus.MATCH_CNT),   2);
        chk("table nomatch_cnt", int'(bus.NOMATCH_CNT), 1);
        chk("table tmo_cnt",     int'(bus.TMO_CNT),     4);
        chk("table ovlp_cnt",    int'(bus.OVLP_CNT),    1);

        // Reset in the middle of a WIN=7 window: nothing may follow.
        set_in(1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
        step(1'b1, "rstwin t0");
        set_in(1'b1, 1'b0, 1'b0, 4'd7, 1'b0);
        step(1'b1, "rstwin t1");
        step(1'b1, "rstwin t2");
        RST_N = 1'b0;
        step(1'b1, "rstwin t3");
        chk("rstwin open", int'(bus.WIN_OPEN), 0);
        chk("rstwin tmo_cnt", int'(bus.TMO_CNT), 0);
        chk("rstwin match_cnt", int'(bus.MATCH_CNT), 0);
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, "rstwin after");
            chk($sformatf("rstwin tmo after %0d", i), int'(bus.LCT_TMO), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            RST_N = ($urandom_range(0, 299) != 0);
            set_in($urandom_range(0, 9) != 0,
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 5) == 0,
                   ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                   $urandom_range(0, 59) == 0);
            step(1'b1, $sformatf("rand%0d", i));
        end
        RST_N = 1'b1;

        // Saturation of NOMATCH_CNT, then clear racing an event.
        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b1, "sat clr");
        set_in(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 65537; i++) step(1'b0, "sat");
        compare_model("sat end");
        chk("sat nomatch_cnt", int'(bus.NOMATCH_CNT), SAT);
        set_in(1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
        step(1'b1, "clr vs event");
        chk("clr vs event nomatch_cnt", int'(bus.NOMATCH_CNT), 0);
        chk("clr vs event pulse", int'(bus.L1A_NOMATCH), 1);
        set_in(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        step(1'b1, "post clr");
        chk("post clr nomatch_cnt", int'(bus.NOMATCH_CNT), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
